// File: rtl/can_mem_arb_pkg.sv
// Shared types and constants for the CAN message-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package can_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Requester slots as wired in the controller top level
  localparam int REQ_RX   = 0;
  localparam int REQ_TX   = 1;
  localparam int REQ_HOST = 2;

  // Default memory geometry
  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  // Width of a requester index; never zero so a 1-requester build still elaborates
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_mem_arb_pick.sv
// Winner selection among pending requesters (fixed or round-robin).
// Latency: combinational.
// Backpressure: none; a winner is offered whenever any req bit is set.
// Build option: define CAN_MEM_ARB_RR_EN for round-robin starting after `last`.
module can_mem_arb_pick
  import can_mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);

`ifndef CAN_MEM_ARB_RR_EN
  // Fixed priority ignores the previous grant
  logic unused_last;
  assign unused_last = ^last;
`endif

  // Scan requesters from the start point and take the first one pending
  always_comb begin
    int start;
    int cand;
    logic found;
    logic [IW-1:0] ci;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    ci      = '0;
`ifdef CAN_MEM_ARB_RR_EN
    start = (int'(last) + 1) % NREQ;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand = (start + k) % NREQ;
      ci   = IW'(cand);
      if (!found && req[ci]) begin
        found       = 1'b1;
        win_oh[ci]  = 1'b1;
        win_idx     = ci;
      end
    end
  end

endmodule

// File: rtl/can_mem_arbiter.sv
// Single-port CAN message memory arbiter: IDLE -> ISSUE [-> WAIT] -> IDLE per access.
// Latency: gnt 1 cycle after req; rvalid 2 (RD_LAT=0) or 3 (RD_LAT=1) cycles after req.
// Backpressure: requesters hold req/rw/addr/din until gnt; losers simply wait.
// Build option: CAN_MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module can_mem_arbiter
  import can_mem_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              mem_rw,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  logic [NREQ-1:0] sel_oh;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   last;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] din_a  [NREQ];

  // Unflatten the request buses so the winner can be muxed by index
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*AW +: AW];
    assign din_a[g]  = req_din[g*DW +: DW];
  end

  can_mem_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef CAN_MEM_ARB_RR_EN
  logic [IW-1:0] sel_idx;

  // Remember who was served so the next search starts just after them
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IW'(NREQ - 1);
    end else if (state == ISSUE) begin
      last <= sel_idx;
    end
  end

  // Index of the requester currently being served
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx <= '0;
    end else if (state == IDLE && |req) begin
      sel_idx <= win_idx;
    end
  end
`else
  assign last = IW'(NREQ - 1);
`endif

  assign busy = (state != IDLE);

  // Access sequencer; memory pins are registered so the memory sees clean levels
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_oh   <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      mem_rw   <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
          mem_rw <= 1'b1;
          if (|req) begin
            sel_oh   <= win_oh;
            gnt      <= win_oh;
            mem_rw   <= req_rw[win_idx];
            mem_addr <= addr_a[win_idx];
            mem_din  <= din_a[win_idx];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // A write completes on this edge; drop back to read immediately after
          mem_rw <= 1'b1;
          if (!mem_rw) begin
            state <= IDLE;
          end else if (RD_LAT == 0) begin
            rdata  <= mem_dout;
            rvalid <= sel_oh;
            state  <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rdata  <= mem_dout;
          rvalid <= sel_oh;
          state  <= IDLE;
        end
        default: begin
          mem_rw <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_mem_arbiter.sv
// Directed bench for can_mem_arbiter: one RD_LAT=0 and one RD_LAT=1 instance.
// Latency: n/a.
// Backpressure: bench requesters hold requests until gnt, as a real requester would.
module tb_can_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  // Instance 0, RD_LAT=0
  logic [2:0]  req0 = '0, rw0 = '1;
  logic [23:0] addr0 = '0, din0 = '0;
  logic [2:0]  gnt0, rvalid0;
  logic [7:0]  rdata0, maddr0, mdin0, mdout0;
  logic        busy0, mrw0;

  // Instance 1, RD_LAT=1
  logic [2:0]  req1 = '0, rw1 = '1;
  logic [23:0] addr1 = '0, din1 = '0;
  logic [2:0]  gnt1, rvalid1;
  logic [7:0]  rdata1, maddr1, mdin1, mdout1;
  logic        busy1, mrw1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int n_chk  = 0;
  int n_fail = 0;

  can_mem_arbiter #(.NREQ(3), .AW(8), .DW(8), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_rw(rw0), .req_addr(addr0), .req_din(din0),
    .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .busy(busy0),
    .mem_rw(mrw0), .mem_addr(maddr0), .mem_din(mdin0), .mem_dout(mdout0)
  );

  can_mem_arbiter #(.NREQ(3), .AW(8), .DW(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_rw(rw1), .req_addr(addr1), .req_din(din1),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .busy(busy1),
    .mem_rw(mrw1), .mem_addr(maddr1), .mem_din(mdin1), .mem_dout(mdout1)
  );

  // Memory 0: combinational read, write on edge when rw=0; preset to ~addr
  assign mdout0 = mem0[maddr0];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 8'(i) ^ 8'hFF;
    end else if (!mrw0) begin
      mem0[maddr0] <= mdin0;
    end
  end

  // Memory 1: registered read, write on edge when rw=0; preset to addr
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 8'(i);
      mdout1 <= '0;
    end else begin
      if (!mrw1) mem1[maddr1] <= mdin1;
      mdout1 <= mem1[maddr1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input int i, input logic v, input logic rw, input logic [7:0] a, input logic [7:0] d);
    req0[i] = v;
    rw0[i]  = rw;
    addr0[i*8 +: 8] = a;
    din0[i*8 +: 8]  = d;
  endtask

  initial begin
    int exp_idx;
    int bad;
    logic [7:0] exp_byte;

    // ---- Reset state ----
    repeat (3) step();
    mem_init = 1'b0;
    check("rst_gnt", gnt0, 0);
    check("rst_rvalid", rvalid0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_busy", busy0, 0);
    check("rst_mem_rw", mrw0, 1);
    check("rst_mem_addr", maddr0, 0);
    check("rst_mem_din", mdin0, 0);
    rst = 1'b0;
    step();

    // ---- Host write 0x55 <- 0x55, then read it back ----
    drive0(2, 1'b1, 1'b0, 8'h55, 8'h55);
    step();
    check("wr_gnt", gnt0, 3'b100);
    check("wr_mem_rw", mrw0, 0);
    check("wr_busy", busy0, 1);
    check("wr_mem_addr", maddr0, 8'h55);
    check("wr_mem_din", mdin0, 8'h55);
    drive0(2, 1'b1, 1'b1, 8'h55, 8'h00);
    step();
    check("wr_idle_gnt", gnt0, 0);
    check("wr_idle_mem_rw", mrw0, 1);
    check("wr_idle_busy", busy0, 0);
    check("wr_mem_written", mem0[8'h55], 8'h55);
    step();
    check("rd_gnt", gnt0, 3'b100);
    check("rd_mem_rw", mrw0, 1);
    check("rd_rvalid_early", rvalid0, 0);
    drive0(2, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check("rd_rvalid", rvalid0, 3'b100);
    check("rd_rdata", rdata0, 8'h55);
    check("rd_gnt_none", gnt0, 0);
    step();
    check("rd_rvalid_pulse", rvalid0, 0);

    // ---- Contention: req0 @0x10 and req2 @0x20 together ----
    drive0(0, 1'b1, 1'b1, 8'h10, 8'h00);
    drive0(2, 1'b1, 1'b1, 8'h20, 8'h00);
    step();
    check("ct_c1_gnt", gnt0, 3'b001);
    check("ct_c1_addr", maddr0, 8'h10);
    drive0(0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check("ct_c2_rvalid", rvalid0, 3'b001);
    check("ct_c2_rdata", rdata0, 8'hEF);
    check("ct_c2_gnt", gnt0, 0);
    step();
    check("ct_c3_gnt", gnt0, 3'b100);
    check("ct_c3_addr", maddr0, 8'h20);
    drive0(2, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check("ct_c4_rvalid", rvalid0, 3'b100);
    check("ct_c4_rdata", rdata0, 8'hDF);
    step();

    // ---- Grant order with all three holding read requests ----
    drive0(0, 1'b1, 1'b1, 8'h01, 8'h00);
    drive0(1, 1'b1, 1'b1, 8'h02, 8'h00);
    drive0(2, 1'b1, 1'b1, 8'h03, 8'h00);
    for (int g = 0; g < 6; g++) begin
`ifdef CAN_MEM_ARB_RR_EN
      exp_idx = g % 3;
`else
      exp_idx = 0;
`endif
      step();
      check($sformatf("order_gnt%0d", g), gnt0, 32'(1) << exp_idx);
      step();
      check($sformatf("order_rdata%0d", g), rdata0, 8'(exp_idx + 1) ^ 8'hFF);
    end
    req0 = '0;
    step();
    step();

    // ---- Idle hygiene: 20 cycles with nothing requested ----
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("idle_mem_rw%0d", c), mrw0, 1);
    end
    check("idle_busy", busy0, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      exp_byte = (i == 8'h55) ? 8'h55 : (8'(i) ^ 8'hFF);
      if (mem0[i] !== exp_byte) bad++;
    end
    check("idle_mem_intact", bad, 0);

    // ---- Reset while a read is in ISSUE ----
    drive0(0, 1'b1, 1'b1, 8'h30, 8'h00);
    step();
    check("ri_gnt", gnt0, 3'b001);
    rst = 1'b1;
    drive0(0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check("ri_gnt_after", gnt0, 0);
    check("ri_busy", busy0, 0);
    check("ri_mem_rw", mrw0, 1);
    check("ri_rdata", rdata0, 0);
    check("ri_rvalid", rvalid0, 0);
    rst = 1'b0;
    drive0(0, 1'b1, 1'b1, 8'h40, 8'h00);
    step();
    check("ri_next_rvalid", rvalid0, 0);
    check("ri_next_gnt", gnt0, 3'b001);
    drive0(0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check("ri_next_rv", rvalid0, 3'b001);
    check("ri_next_rdata", rdata0, 8'hBF);
    step();

    // ---- RD_LAT=1: read 0xAA goes IDLE, ISSUE, WAIT, IDLE ----
    req1[0] = 1'b1; rw1[0] = 1'b1; addr1[7:0] = 8'hAA;
    step();
    check("l1_issue_gnt", gnt1, 3'b001);
    check("l1_issue_busy", busy1, 1);
    req1[0] = 1'b0;
    step();
    check("l1_wait_busy", busy1, 1);
    check("l1_wait_gnt", gnt1, 0);
    check("l1_wait_rvalid", rvalid1, 0);
    check("l1_wait_addr", maddr1, 8'hAA);
    step();
    check("l1_rvalid", rvalid1, 3'b001);
    check("l1_rdata", rdata1, 8'hAA);
    check("l1_idle_busy", busy1, 0);

    // RD_LAT=1 write via TX requester, then read it back
    req1[1] = 1'b1; rw1[1] = 1'b0; addr1[15:8] = 8'h0F; din1[15:8] = 8'h3C;
    step();
    check("l1_wr_gnt", gnt1, 3'b010);
    check("l1_wr_mem_rw", mrw1, 0);
    rw1[1] = 1'b1;
    step();
    check("l1_wr_done_busy", busy1, 0);
    check("l1_wr_done_rw", mrw1, 1);
    step();
    check("l1_rb_gnt", gnt1, 3'b010);
    req1[1] = 1'b0;
    step();
    step();
    check("l1_rb_rvalid", rvalid1, 3'b010);
    check("l1_rb_rdata", rdata1, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
